// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline: memory access size encodings, the MEM
// stage state machine encoding and small alignment helpers.
package cpu_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } memState_e;

  // A double access on a 32-bit datapath degrades to a word access.
  function automatic logic [1:0] effSize(input logic [1:0] size, input logic wide);
    return (size == MEM_D && !wide) ? MEM_W : size;
  endfunction

  function automatic logic isMisaligned(input logic [2:0] addrLow, input logic [1:0] size);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = addrLow[0];
      MEM_W:   mis = |addrLow[1:0];
      default: mis = |addrLow;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed lane of the read data and
// sign- or zero-extends it to the full datapath width.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lowMask;
  logic              signBit;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    signBit = 1'b0;
    lowMask = '1;
    case (size_i)
      MEM_B: begin
        signBit = shifted[7];
        lowMask = DATA_W'(8'hFF);
      end
      MEM_H: begin
        signBit = shifted[15];
        lowMask = DATA_W'(16'hFFFF);
      end
      MEM_W: begin
        signBit = shifted[31];
        lowMask = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        signBit = shifted[DATA_W-1];
        lowMask = '1;
      end
    endcase
  end

  assign data_o = (shifted & lowMask) | ((signBit && !unsigned_i) ? ~lowMask : '0);

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EXE and WB: issues one request at a
// time on a stallable addr_ok/data_ok bus and aligns load/store data.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exe_to_mem_valid,
  output logic                mem_allowin,
  input  logic [ADDR_W-1:0]   exe_pc,
  input  logic [DATA_W-1:0]   exe_alu_result,
  input  logic                exe_rf_we,
  input  logic [RF_AW-1:0]    exe_rf_waddr,
  input  logic                exe_res_from_mem,
  input  logic                exe_mem_we,
  input  logic [1:0]          exe_mem_size,
  input  logic                exe_mem_unsigned,
  input  logic [DATA_W-1:0]   exe_rkd_value,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [ADDR_W-1:0]   mem_pc,
  output logic                mem_rf_we,
  output logic [RF_AW-1:0]    mem_rf_waddr,
  output logic [DATA_W-1:0]   mem_rf_wdata,
  output logic                mem_ale,
  output logic                mem_load_pending,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  localparam int   NB     = DATA_W / 8;
  localparam int   LANE_W = $clog2(NB);
  localparam logic WIDE   = (DATA_W == 64);

  logic              memValid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] aluResult_q;
  logic              rfWe_q;
  logic [RF_AW-1:0]  rfWaddr_q;
  logic              resFromMem_q;
  logic              memWe_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] rkdValue_q;
  logic [DATA_W-1:0] rdata_q;
  memState_e         state_q, state_d;
  logic              rspLatch;

  logic [1:0]        exeSize;
  logic              exeCapture;
  logic              captureMem;
  logic              isMem;
  logic              misaligned;
  logic              readyGo;
  logic [LANE_W-1:0] lane;
  logic [NB-1:0]     byteMask;
  logic [DATA_W-1:0] storeData;
  logic [DATA_W-1:0] loadData;

  assign exeSize    = effSize(exe_mem_size, WIDE);
  assign exeCapture = exe_to_mem_valid & mem_allowin;
  assign captureMem = exeCapture & (exe_res_from_mem | exe_mem_we)
                    & ~isMisaligned(exe_alu_result[2:0], exeSize);

  assign isMem      = resFromMem_q | memWe_q;
  assign misaligned = isMem & isMisaligned(aluResult_q[2:0], size_q);
  assign readyGo    = ~isMem | misaligned | (state_q == ST_DONE);
  assign lane       = aluResult_q[LANE_W-1:0];

  assign mem_allowin     = ~memValid_q | (readyGo & wb_allowin);
  assign mem_to_wb_valid = memValid_q & readyGo;

  always_ff @(posedge clk) begin
    if (reset) begin
      memValid_q   <= 1'b0;
      pc_q         <= '0;
      aluResult_q  <= '0;
      rfWe_q       <= 1'b0;
      rfWaddr_q    <= '0;
      resFromMem_q <= 1'b0;
      memWe_q      <= 1'b0;
      size_q       <= MEM_B;
      unsigned_q   <= 1'b0;
      rkdValue_q   <= '0;
    end else begin
      if (mem_allowin) memValid_q <= exe_to_mem_valid;
      if (exeCapture) begin
        pc_q         <= exe_pc;
        aluResult_q  <= exe_alu_result;
        rfWe_q       <= exe_rf_we;
        rfWaddr_q    <= exe_rf_waddr;
        resFromMem_q <= exe_res_from_mem;
        memWe_q      <= exe_mem_we;
        size_q       <= exeSize;
        unsigned_q   <= exe_mem_unsigned;
        rkdValue_q   <= exe_rkd_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (rspLatch) rdata_q <= data_rdata;
    end
  end

  // DONE may hand over directly to REQ so back-to-back memory ops add no bubble.
  always_comb begin
    state_d  = state_q;
    rspLatch = 1'b0;
    case (state_q)
      ST_IDLE: if (captureMem) state_d = ST_REQ;
      ST_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d  = ST_DONE;
            rspLatch = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          state_d  = ST_DONE;
          rspLatch = 1'b1;
        end
      end
      ST_DONE: if (wb_allowin) state_d = captureMem ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      MEM_B:   byteMask = NB'(8'h01);
      MEM_H:   byteMask = NB'(8'h03);
      MEM_W:   byteMask = NB'(8'h0F);
      default: byteMask = NB'(8'hFF);
    endcase
  end

  always_comb begin
    storeData = '0;
    for (int i = 0; i < NB; i++) begin
      storeData[i*8 +: 8] = rkdValue_q[(i % (1 << size_q))*8 +: 8];
    end
  end

  load_align #(
    .DATA_W(DATA_W),
    .LANE_W(LANE_W)
  ) u_load_align (
    .rdata_i   (rdata_q),
    .lane_i    (lane),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .data_o    (loadData)
  );

  assign data_req   = (state_q == ST_REQ);
  assign data_wr    = data_req & memWe_q;
  assign data_size  = size_q;
  assign data_addr  = aluResult_q[ADDR_W-1:0];
  assign data_wdata = storeData;
  assign data_wstrb = (memValid_q & memWe_q) ? (byteMask << lane) : '0;

  assign mem_pc           = pc_q;
  assign mem_ale          = memValid_q & misaligned;
  assign mem_rf_we        = memValid_q & rfWe_q & ~misaligned;
  assign mem_rf_waddr     = rfWaddr_q;
  assign mem_rf_wdata     = resFromMem_q ? loadData : aluResult_q;
  assign mem_load_pending = memValid_q & resFromMem_q & ~misaligned & (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage on a 32-bit datapath with
// hand-computed expectations and a manually driven data-memory handshake.
module tb_mem_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int RF_AW  = 5;

  logic                clk;
  logic                reset;
  logic                exe_to_mem_valid;
  logic                mem_allowin;
  logic [ADDR_W-1:0]   exe_pc;
  logic [DATA_W-1:0]   exe_alu_result;
  logic                exe_rf_we;
  logic [RF_AW-1:0]    exe_rf_waddr;
  logic                exe_res_from_mem;
  logic                exe_mem_we;
  logic [1:0]          exe_mem_size;
  logic                exe_mem_unsigned;
  logic [DATA_W-1:0]   exe_rkd_value;
  logic                wb_allowin;
  logic                mem_to_wb_valid;
  logic [ADDR_W-1:0]   mem_pc;
  logic                mem_rf_we;
  logic [RF_AW-1:0]    mem_rf_waddr;
  logic [DATA_W-1:0]   mem_rf_wdata;
  logic                mem_ale;
  logic                mem_load_pending;
  logic                data_req;
  logic                data_wr;
  logic [1:0]          data_size;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_W-1:0]   data_rdata;

  int assertCount = 0;
  int failCount   = 0;

  mem_stage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RF_AW (RF_AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .exe_to_mem_valid(exe_to_mem_valid),
    .mem_allowin     (mem_allowin),
    .exe_pc          (exe_pc),
    .exe_alu_result  (exe_alu_result),
    .exe_rf_we       (exe_rf_we),
    .exe_rf_waddr    (exe_rf_waddr),
    .exe_res_from_mem(exe_res_from_mem),
    .exe_mem_we      (exe_mem_we),
    .exe_mem_size    (exe_mem_size),
    .exe_mem_unsigned(exe_mem_unsigned),
    .exe_rkd_value   (exe_rkd_value),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_pc          (mem_pc),
    .mem_rf_we       (mem_rf_we),
    .mem_rf_waddr    (mem_rf_waddr),
    .mem_rf_wdata    (mem_rf_wdata),
    .mem_ale         (mem_ale),
    .mem_load_pending(mem_load_pending),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_wstrb      (data_wstrb),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] alu,
                               input logic rfWe, input logic [4:0] waddr, input logic isLoad,
                               input logic isStore, input logic [1:0] size, input logic uns,
                               input logic [31:0] rkd);
    exe_to_mem_valid = valid;
    exe_pc           = pc;
    exe_alu_result   = alu;
    exe_rf_we        = rfWe;
    exe_rf_waddr     = waddr;
    exe_res_from_mem = isLoad;
    exe_mem_we       = isStore;
    exe_mem_size     = size;
    exe_mem_unsigned = uns;
    exe_rkd_value    = rkd;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset         = 1'b1;
    wb_allowin    = 1'b1;
    data_addr_ok  = 1'b0;
    data_data_ok  = 1'b0;
    data_rdata    = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_allowin", mem_allowin, 1);
    checkOutput("rst_valid", mem_to_wb_valid, 0);
    checkOutput("rst_req", data_req, 0);
    checkOutput("rst_wstrb", data_wstrb, 0);
    checkOutput("rst_pending", mem_load_pending, 0);
    checkOutput("rst_wdata", mem_rf_wdata, 0);

    $display("[TB] non-memory op");
    applyStimulus(1'b1, 32'h1000, 32'h1234, 1'b1, 5'd5, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("alu_valid", mem_to_wb_valid, 1);
    checkOutput("alu_wdata", mem_rf_wdata, 32'h1234);
    checkOutput("alu_rfwe", mem_rf_we, 1);
    checkOutput("alu_waddr", mem_rf_waddr, 5);
    checkOutput("alu_pc", mem_pc, 32'h1000);
    checkOutput("alu_noreq", data_req, 0);
    nextCycle();
    checkOutput("alu_gone", mem_to_wb_valid, 0);

    $display("[TB] ld.b with minimum latency");
    applyStimulus(1'b1, 32'h1004, 32'h103, 1'b1, 5'd6, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("ldb_req", data_req, 1);
    checkOutput("ldb_wr", data_wr, 0);
    checkOutput("ldb_addr", data_addr, 32'h103);
    checkOutput("ldb_size", data_size, 0);
    checkOutput("ldb_allowin", mem_allowin, 0);
    checkOutput("ldb_pending", mem_load_pending, 1);
    checkOutput("ldb_notvalid", mem_to_wb_valid, 0);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_FF00;
    nextCycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    // ld.bu presented while the ld.b retires: captured on the same edge
    applyStimulus(1'b1, 32'h1008, 32'h103, 1'b1, 5'd7, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0);
    #1;
    checkOutput("ldb_valid", mem_to_wb_valid, 1);
    checkOutput("ldb_wdata", mem_rf_wdata, 32'hFFFF_FF80);
    checkOutput("ldb_done_pending", mem_load_pending, 0);
    checkOutput("ldb_done_req", data_req, 0);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("ldbu_b2b_req", data_req, 1);
    checkOutput("ldbu_waddr", mem_rf_waddr, 7);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_FF00;
    nextCycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    #1;
    checkOutput("ldbu_wdata", mem_rf_wdata, 32'h0000_0080);
    nextCycle();

    $display("[TB] ld.h sign extension");
    applyStimulus(1'b1, 32'h100C, 32'h402, 1'b1, 5'd8, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h8001_7FFF;
    nextCycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    #1;
    checkOutput("ldh_wdata", mem_rf_wdata, 32'hFFFF_8001);
    nextCycle();

    $display("[TB] st.h with separate addr_ok and data_ok");
    applyStimulus(1'b1, 32'h1010, 32'h202, 1'b0, 5'd0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("sth_req", data_req, 1);
    checkOutput("sth_wr", data_wr, 1);
    checkOutput("sth_wstrb", data_wstrb, 4'b1100);
    checkOutput("sth_wdata", data_wdata, 32'hABCD_ABCD);
    checkOutput("sth_pending", mem_load_pending, 0);
    data_addr_ok = 1'b1;
    nextCycle();
    data_addr_ok = 1'b0;
    #1;
    checkOutput("sth_wait_req", data_req, 0);
    checkOutput("sth_wait_valid", mem_to_wb_valid, 0);
    checkOutput("sth_wait_allowin", mem_allowin, 0);
    data_data_ok = 1'b1;
    nextCycle();
    data_data_ok = 1'b0;
    #1;
    checkOutput("sth_done_valid", mem_to_wb_valid, 1);
    checkOutput("sth_rfwe", mem_rf_we, 0);
    nextCycle();

    $display("[TB] ld.w with delayed handshake");
    applyStimulus(1'b1, 32'h1014, 32'h300, 1'b1, 5'd9, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("slow_req", data_req, 1);
      checkOutput("slow_addr", data_addr, 32'h300);
      checkOutput("slow_pending", mem_load_pending, 1);
      checkOutput("slow_allowin", mem_allowin, 0);
      nextCycle();
    end
    data_addr_ok = 1'b1;
    #1;
    checkOutput("slow_req_acc", data_req, 1);
    nextCycle();
    data_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("slow_wait_req", data_req, 0);
      checkOutput("slow_wait_pending", mem_load_pending, 1);
      checkOutput("slow_wait_allowin", mem_allowin, 0);
      nextCycle();
    end
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    nextCycle();
    data_data_ok = 1'b0;
    data_rdata   = 32'h5555_AAAA;
    wb_allowin   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("hold_valid", mem_to_wb_valid, 1);
      checkOutput("hold_wdata", mem_rf_wdata, 32'hDEAD_BEEF);
      checkOutput("hold_allowin", mem_allowin, 0);
      checkOutput("hold_pending", mem_load_pending, 0);
      nextCycle();
    end
    wb_allowin = 1'b1;
    applyStimulus(1'b1, 32'h1018, 32'h304, 1'b1, 5'd10, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
    #1;
    checkOutput("retire_allowin", mem_allowin, 1);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("b2b_req", data_req, 1);
    checkOutput("b2b_addr", data_addr, 32'h304);
    data_addr_ok = 1'b1;
    nextCycle();
    data_addr_ok = 1'b0;
    #1;
    checkOutput("b2b_wait_pending", mem_load_pending, 1);

    $display("[TB] reset while waiting");
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rstw_valid", mem_to_wb_valid, 0);
    checkOutput("rstw_req", data_req, 0);
    checkOutput("rstw_pending", mem_load_pending, 0);
    checkOutput("rstw_allowin", mem_allowin, 1);
    nextCycle();

    $display("[TB] misaligned ld.w");
    applyStimulus(1'b1, 32'h101C, 32'h101, 1'b1, 5'd11, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("ale_req", data_req, 0);
    checkOutput("ale_flag", mem_ale, 1);
    checkOutput("ale_rfwe", mem_rf_we, 0);
    checkOutput("ale_valid", mem_to_wb_valid, 1);
    checkOutput("ale_allowin", mem_allowin, 1);
    checkOutput("ale_pending", mem_load_pending, 0);
    nextCycle();
    #1;
    checkOutput("ale_gone", mem_ale, 0);
    checkOutput("ale_noreq", data_req, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory-access stage of the five-stage pipeline, sitting between EXE and WB. It supports byte, half, word and, when DATA_W=64, double accesses, with sign or zero extension on loads. It drives a request/response data-memory interface (addr_ok/data_ok) that may stall for any number of cycles. It also flags misaligned accesses, and gives ID both a forwarding bundle and a load-pending indication for interlock.

## Interface
- DATA_W, 32, datapath/bus width; 32 or 64 only
- ADDR_W, 32, address and PC width
- RF_AW, 5, register-file address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exe_to_mem_valid  in  1  EXE holds a valid instruction
- mem_allowin  out  1  MEM accepts an instruction this cycle
- exe_pc  in  ADDR_W  instruction PC
- exe_alu_result  in  DATA_W  effective address, or ALU result for non-memory ops
- exe_rf_we / exe_rf_waddr  in  1 / RF_AW  destination register
- exe_res_from_mem  in  1  load
- exe_mem_we  in  1  store
- exe_mem_size  in  2  0 byte, 1 half, 2 word, 3 double (DATA_W=64 only)
- exe_mem_unsigned  in  1  zero-extend load
- exe_rkd_value  in  DATA_W  store data
- wb_allowin  in  1  WB accepts
- mem_to_wb_valid  out  1  result valid toward WB
- mem_pc  out  ADDR_W  PC toward WB
- mem_rf_we / mem_rf_waddr / mem_rf_wdata  out  1 / RF_AW / DATA_W  writeback bundle; mem_rf_we is gated by valid and ~mem_ale
- mem_ale  out  1  misaligned access flagged toward WB
- mem_load_pending  out  1  valid load whose data has not returned; ID must stall on a RAW hit
- data_req  out  1  request valid
- data_wr  out  1  write request
- data_size  out  2  access size
- data_wstrb  out  DATA_W/8  byte enables
- data_addr  out  ADDR_W  request address
- data_wdata  out  DATA_W  lane-aligned store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data returned / write complete
- data_rdata  in  DATA_W  read data

## Operation
- Input registers capture EXE fields on clk when exe_to_mem_valid & mem_allowin. mem_valid loads exe_to_mem_valid whenever mem_allowin is high.
- mem_allowin = ~mem_valid | (ready_go & wb_allowin). ready_go is 1 for non-memory ops, misaligned ops, and in state DONE.
- FSM states:
  - IDLE: no memory op outstanding. On capture of an aligned load or store, go to REQ; otherwise stay in IDLE.
  - REQ: data_req=1. On addr_ok, go to WAIT. If addr_ok and data_ok are both high in the same cycle, go directly to DONE.
  - WAIT: on data_ok, latch data_rdata into the response buffer and go to DONE.
  - DONE: when wb_allowin is high, go to REQ if an aligned memory op is captured on the same edge, else IDLE.
- Alignment: the access is misaligned when addr[log2(bytes)-1:0] != 0. Misaligned ops never assert data_req, set mem_ale=1 and suppress mem_rf_we.
- Lane offset: lane = addr[log2(DATA_W/8)-1:0].
- Stores:
  - data_wstrb = ((1<<bytes)-1) << lane.
  - data_wdata = rkd_value[bytes*8-1:0] replicated across all lanes.
- Loads:
  - Shift the buffered rdata right by lane*8.
  - Take the low bytes*8 bits.
  - Sign-extend to DATA_W, or zero-extend when exe_mem_unsigned is set.
- mem_rf_wdata = extended load data if res_from_mem, else alu_result.
- mem_load_pending = mem_valid & res_from_mem & ~mem_ale & (state != DONE).
- exe_mem_size=3 with DATA_W=32 is treated as a word access.
- data_data_ok while in IDLE or REQ (without addr_ok) is ignored.

## Timing
- Reset: mem_valid=0, state=IDLE, all pipeline registers 0. All outputs are 0 except mem_allowin=1.
- Non-memory op captured at edge N: mem_to_wb_valid is high in cycle N and the op leaves at the first edge where wb_allowin=1.
- Memory op captured at edge N: data_req is high from cycle N until addr_ok (held for ≥1 cycle). data_req, data_addr, data_size, data_wstrb and data_wdata stay stable while waiting.
- data_ok in cycle M: mem_to_wb_valid goes high from cycle M+1. Minimum load latency is 2 cycles in MEM, with addr_ok and data_ok both arriving in cycle N.
- DONE holds the buffered result stable through any number of cycles with wb_allowin=0.
- Back-to-back: a new op is captured on the same edge that DONE retires; no bubble is added.
- At most one request is outstanding; a new request is issued only after data_ok.
- Reset asserted in REQ/WAIT/DONE: the state returns to IDLE on the next edge, and the memory side is reset together with this block.

## Structure
- Shared package (cpu_pkg): the size encodings MEM_B/MEM_H/MEM_W/MEM_D and the FSM state enum.
- Sub-module load_align (combinational): rdata, lane, size, unsigned → extended DATA_W value.
- store_align logic stays inline; it is small.

## Test plan
- Non-memory op: alu_result=0x1234, wb_allowin=1 → mem_to_wb_valid in the capture cycle, mem_rf_wdata=0x1234, data_req never asserted.
- ld.b at addr 0x...3, rdata=0x80FF_FF00 → mem_rf_wdata=0xFFFF_FF80; repeated as ld.bu → 0x0000_0080.
- st.h at addr 0x...2, rkd=0xABCD → data_wstrb=4'b1100, data_wdata=0xABCD_ABCD; DONE follows data_ok.
- addr_ok delayed 3 cycles and data_ok delayed 4 more → data_req and data_addr stable throughout, mem_load_pending=1 until DONE, mem_allowin=0.
- ld.w at addr 0x...1 → no data_req, mem_ale=1, mem_rf_we=0, retires in the capture cycle.
- wb_allowin=0 for 5 cycles in DONE, then a back-to-back load → result held stable, the next request issues in the cycle after retire; reset asserted in WAIT → state IDLE, mem_valid=0 next cycle.
